// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Define MC_SYSTEM_EN to decode opcode 1110011 as a system trap (cause 11) instead of illegal.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       branch_taken_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       op_q, op_d;
    logic [1:0]       cause_q, cause_d;
    logic             timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cause_q <= cause_d;
        end
    end

    // A ready in the final allowed wait cycle still completes the request.
    assign timeout = (cnt_q == CNT_LAST) && !mem_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode_i;
                case (opcode_i)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_EXEC;
`ifdef MC_SYSTEM_EN
                    OP_SYS: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_SYSTEM;
                    end
`else
                    OP_SYS: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
`endif
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_LOAD, OP_STORE: begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                    OP_BR: begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
                    OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_WB;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_TRAP: state_d = S_TRAP;
            default: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, regardless of the registered state.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        addr_src_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        result_src_o = 2'b00;
        trap_o       = 1'b0;
        trap_cause_o = CAUSE_NONE;
        state_o      = 3'd0;
        if (!rst_i) begin
            state_o = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'b10;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: begin
                            alu_src_a_o = 2'b01;
                            alu_op_o    = 2'b10;
                        end
                        OP_I: begin
                            alu_src_a_o = 2'b01;
                            alu_src_b_o = 2'b01;
                            alu_op_o    = 2'b11;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a_o = 2'b01;
                            alu_src_b_o = 2'b01;
                        end
                        OP_BR: begin
                            alu_src_a_o = 2'b01;
                            alu_op_o    = 2'b01;
                            pc_write_o  = branch_taken_i;
                            pc_src_o    = 2'b01;
                        end
                        OP_JAL: begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 2'b01;
                        end
                        OP_JALR: begin
                            alu_src_a_o = 2'b01;
                            alu_src_b_o = 2'b01;
                            pc_write_o  = 1'b1;
                            pc_src_o    = 2'b10;
                        end
                        OP_LUI: begin
                            alu_src_a_o = 2'b10;
                            alu_src_b_o = 2'b01;
                        end
                        OP_AUIPC: begin
                            alu_src_a_o = 2'b11;
                            alu_src_b_o = 2'b01;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req_o  = 1'b1;
                    addr_src_o = 1'b1;
                    mem_we_o   = (op_q == OP_STORE);
                end
                S_WB: begin
                    reg_write_o = 1'b1;
                    if (op_q == OP_LOAD)
                        result_src_o = 2'b01;
                    else if (op_q == OP_JAL || op_q == OP_JALR)
                        result_src_o = 2'b10;
                end
                S_TRAP: begin
                    trap_o       = 1'b1;
                    trap_cause_o = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller; expectations are built per
// instruction from its phase sequence (fetch waits, decode, exec, mem waits, writeback).
module tb_multicycle_controller;

    localparam int TO = 4;

    localparam logic [2:0] P_FETCH  = 3'd0;
    localparam logic [2:0] P_DECODE = 3'd1;
    localparam logic [2:0] P_EXEC   = 3'd2;
    localparam logic [2:0] P_MEM    = 3'd3;
    localparam logic [2:0] P_WB     = 3'd4;
    localparam logic [2:0] P_TRAP   = 3'd7;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

`ifdef MC_SYSTEM_EN
    localparam logic [1:0] SYS_CAUSE = 2'b11;
`else
    localparam logic [1:0] SYS_CAUSE = 2'b01;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asrc;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [1:0] rs;
        logic       trap;
        logic [1:0] cause;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req_o, mem_we_o, addr_src_o, ir_write_o, pc_write_o, reg_write_o, trap_o;
    logic [1:0] pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, trap_cause_o;
    logic [2:0] state_o;
    outs_t      act;

    int checks = 0;
    int errors = 0;

    logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    multicycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .branch_taken_i(br_taken),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .addr_src_o(addr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .result_src_o(result_src_o),
        .trap_o(trap_o), .trap_cause_o(trap_cause_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign act = {state_o, mem_req_o, mem_we_o, addr_src_o, ir_write_o, pc_write_o, pc_src_o,
                  reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, trap_o, trap_cause_o};

    // Expected control word for one cycle of a given phase of a given instruction.
    function automatic outs_t expect_outs(input logic [2:0] ph, input logic [6:0] op,
                                          input logic rdy, input logic tk, input logic [1:0] cause);
        outs_t o;
        o = '0;
        o.st = ph;
        case (ph)
            P_FETCH: begin
                o.req = 1'b1; o.b = 2'b10; o.irw = rdy; o.pcw = rdy;
            end
            P_EXEC: begin
                if (op == OP_R)          begin o.a = 2'b01; o.b = 2'b00; o.aop = 2'b10; end
                else if (op == OP_I)     begin o.a = 2'b01; o.b = 2'b01; o.aop = 2'b11; end
                else if (op == OP_LOAD || op == OP_STORE) begin o.a = 2'b01; o.b = 2'b01; end
                else if (op == OP_BR)    begin o.a = 2'b01; o.aop = 2'b01; o.pcw = tk; o.pcs = 2'b01; end
                else if (op == OP_JAL)   begin o.pcw = 1'b1; o.pcs = 2'b01; end
                else if (op == OP_JALR)  begin o.a = 2'b01; o.b = 2'b01; o.pcw = 1'b1; o.pcs = 2'b10; end
                else if (op == OP_LUI)   begin o.a = 2'b10; o.b = 2'b01; end
                else if (op == OP_AUIPC) begin o.a = 2'b11; o.b = 2'b01; end
            end
            P_MEM: begin
                o.req = 1'b1; o.asrc = 1'b1; o.we = (op == OP_STORE);
            end
            P_WB: begin
                o.rw = 1'b1;
                o.rs = (op == OP_LOAD) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00;
            end
            P_TRAP: begin
                o.trap = 1'b1; o.cause = cause;
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input logic r, input logic [6:0] opc, input logic rdy, input logic tk,
                        input outs_t exp, input string name);
        @(negedge clk);
        rst = r; opcode = opc; mem_ready = rdy; br_taken = tk;
        #1;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), '0, "reset_outputs");
    endtask

    // One instruction with fw fetch wait cycles and mw memory wait cycles.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic tk);
        int    cyc;
        logic  rdy;
        cyc = 0;
        for (int i = 0; i <= fw; i++) begin
            rdy = (i == fw);
            step(1'b0, 7'($urandom), rdy, 1'($urandom), expect_outs(P_FETCH, op, rdy, 1'b0, 2'b00), "fetch");
            cyc++;
        end
        rdy = 1'($urandom);
        step(1'b0, op, rdy, 1'($urandom), expect_outs(P_DECODE, op, rdy, 1'b0, 2'b00), "decode");
        cyc++;
        rdy = 1'($urandom);
        step(1'b0, 7'($urandom), rdy, tk, expect_outs(P_EXEC, op, rdy, tk, 2'b00), "exec");
        cyc++;
        if (op == OP_LOAD || op == OP_STORE) begin
            for (int i = 0; i <= mw; i++) begin
                rdy = (i == mw);
                step(1'b0, 7'($urandom), rdy, 1'($urandom), expect_outs(P_MEM, op, rdy, 1'b0, 2'b00), "mem");
                cyc++;
            end
        end
        if (op != OP_BR && op != OP_STORE) begin
            rdy = 1'($urandom);
            step(1'b0, 7'($urandom), rdy, 1'($urandom), expect_outs(P_WB, op, rdy, 1'b0, 2'b00), "wb");
            cyc++;
        end
        $display("instr op=%b fetch_waits=%0d mem_waits=%0d taken=%0d cycles=%0d", op, fw, mw, tk, cyc);
    endtask

    task automatic trap_hold(input logic [1:0] cause, input int n, input string name);
        for (int i = 0; i < n; i++)
            step(1'b0, 7'($urandom), 1'($urandom), 1'($urandom),
                 expect_outs(P_TRAP, 7'd0, 1'b0, 1'b0, cause), name);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) do_reset();
        run_instr(OP_R, 0, 0, 1'b0);
    endtask

    task automatic test_load_waits();
        run_instr(OP_LOAD, 0, 2, 1'b0);
        run_instr(OP_STORE, 1, 3, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(OP_BR, 0, 0, 1'b1);
        run_instr(OP_BR, 0, 0, 1'b0);
    endtask

    task automatic test_illegal();
        do_reset();
        step(1'b0, 7'd0, 1'b1, 1'b0, expect_outs(P_FETCH, 7'd0, 1'b1, 1'b0, 2'b00), "fetch");
        step(1'b0, 7'b1111111, 1'b0, 1'b0, expect_outs(P_DECODE, 7'd0, 1'b0, 1'b0, 2'b00), "decode");
        trap_hold(2'b01, 20, "illegal_trap");
        $display("illegal opcode 1111111 trap checked");
        do_reset();
        step(1'b0, 7'd0, 1'b1, 1'b0, expect_outs(P_FETCH, 7'd0, 1'b1, 1'b0, 2'b00), "fetch");
        step(1'b0, OP_SYS, 1'b0, 1'b0, expect_outs(P_DECODE, 7'd0, 1'b0, 1'b0, 2'b00), "decode");
        trap_hold(SYS_CAUSE, 5, "system_trap");
        $display("system opcode trap checked cause=%0d", SYS_CAUSE);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TO; i++)
            step(1'b0, 7'($urandom), 1'b0, 1'b0, expect_outs(P_FETCH, 7'd0, 1'b0, 1'b0, 2'b00), "fetch_wait");
        trap_hold(2'b10, 5, "fetch_timeout_trap");
        $display("fetch timeout checked");
        do_reset();
        run_instr(OP_I, TO - 1, 0, 1'b0);
        step(1'b0, 7'd0, 1'b1, 1'b0, expect_outs(P_FETCH, 7'd0, 1'b1, 1'b0, 2'b00), "fetch");
        step(1'b0, OP_LOAD, 1'b0, 1'b0, expect_outs(P_DECODE, OP_LOAD, 1'b0, 1'b0, 2'b00), "decode");
        step(1'b0, 7'd0, 1'b0, 1'b0, expect_outs(P_EXEC, OP_LOAD, 1'b0, 1'b0, 2'b00), "exec");
        for (int i = 0; i < TO; i++)
            step(1'b0, 7'd0, 1'b0, 1'b0, expect_outs(P_MEM, OP_LOAD, 1'b0, 1'b0, 2'b00), "mem_wait");
        trap_hold(2'b10, 3, "mem_timeout_trap");
        $display("mem timeout checked");
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b0, 7'd0, 1'b1, 1'b0, expect_outs(P_FETCH, 7'd0, 1'b1, 1'b0, 2'b00), "fetch");
        step(1'b0, OP_STORE, 1'b0, 1'b0, expect_outs(P_DECODE, OP_STORE, 1'b0, 1'b0, 2'b00), "decode");
        step(1'b0, 7'd0, 1'b0, 1'b0, expect_outs(P_EXEC, OP_STORE, 1'b0, 1'b0, 2'b00), "exec");
        step(1'b0, 7'd0, 1'b0, 1'b0, expect_outs(P_MEM, OP_STORE, 1'b0, 1'b0, 2'b00), "mem_wait");
        step(1'b0, 7'd0, 1'b0, 1'b0, expect_outs(P_MEM, OP_STORE, 1'b0, 1'b0, 2'b00), "mem_wait");
        step(1'b1, 7'd0, 1'b1, 1'b1, '0, "mid_reset");
        run_instr(OP_JAL, TO - 1, 0, 1'b0);
        $display("mid-instruction reset checked");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_load_waits();
        test_branch();
        test_random();
        test_illegal();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
